// File: rtl/lcd_result_writer_pkg.sv
// Shared types and constants for the HD44780 result writer: FSM states,
// LCD command bytes, ASCII codes and the power-on command sequence.
package lcd_pkg;

  typedef enum logic [2:0] {
    ST_PWR_WAIT,
    ST_INIT,
    ST_IDLE,
    ST_SNAP,
    ST_LINE1,
    ST_LINE2,
    ST_FINISH
  } state_t;

  localparam logic [7:0] CMD_FUNC_SET = 8'h38;
  localparam logic [7:0] CMD_DISP_ON  = 8'h0C;
  localparam logic [7:0] CMD_ENTRY    = 8'h06;
  localparam logic [7:0] CMD_CLEAR    = 8'h01;
  localparam logic [7:0] CMD_LINE1    = 8'h80;
  localparam logic [7:0] CMD_LINE2    = 8'hC0;

  localparam logic [7:0] CH_SPACE = 8'h20;
  localparam logic [7:0] CH_ZERO  = 8'h30;
  localparam logic [7:0] CH_PCT   = 8'h25;
  localparam logic [7:0] CH_O     = 8'h4F;
  localparam logic [7:0] CH_X     = 8'h58;

  localparam int LINE_LEN = 16;

  // Power-on command sequence; the clear command must be last (longest wait).
  function automatic logic [7:0] init_cmd(input logic [1:0] idx);
    logic [7:0] cmd;
    case (idx)
      2'd0:    cmd = CMD_FUNC_SET;
      2'd1:    cmd = CMD_DISP_ON;
      2'd2:    cmd = CMD_ENTRY;
      default: cmd = CMD_CLEAR;
    endcase
    return cmd;
  endfunction

endpackage

// File: rtl/lcd_result_writer_if.sv
// Request/status handshake and LCD pin bundle of the result writer.
interface lcd_result_writer_if;
  logic       start;
  logic       training_active;
  logic       result_is_O;
  logic [6:0] prob_pct;
  logic [7:0] epoch;
  logic       busy;
  logic       done;
  logic       lcd_e;
  logic       lcd_rw;
  logic       lcd_rs;
  logic [7:0] lcd_data;

  modport master (
    input  start, training_active, result_is_O, prob_pct, epoch,
    output busy, done, lcd_e, lcd_rw, lcd_rs, lcd_data
  );

  modport slave (
    output start, training_active, result_is_O, prob_pct, epoch,
    input  busy, done, lcd_e, lcd_rw, lcd_rs, lcd_data
  );
endinterface

// File: rtl/lcd_result_writer_bin8_to_ascii3.sv
// Combinational 8-bit binary to three ASCII decimal digits, leading zeros
// shown as spaces (the units digit is always printed).
import lcd_pkg::*;

module bin8_to_ascii3 (
  input  logic [7:0] bin,
  output logic [7:0] ch_hund,
  output logic [7:0] ch_tens,
  output logic [7:0] ch_ones
);
  logic [7:0] hund;
  logic [7:0] tens;
  logic [7:0] ones;

  always_comb begin
    hund    = bin / 8'd100;
    tens    = (bin / 8'd10) % 8'd10;
    ones    = bin % 8'd10;
    ch_hund = (hund == 8'd0) ? CH_SPACE : CH_ZERO + hund;
    ch_tens = (hund == 8'd0 && tens == 8'd0) ? CH_SPACE : CH_ZERO + tens;
    ch_ones = CH_ZERO + ones;
  end
endmodule

// File: rtl/lcd_result_writer.sv
// Two-line status writer for a 16x2 HD44780 LCD (8-bit, write-only, timed).
// Optional LCD_AUTO_REFRESH_EN: periodic refresh while training is active.
import lcd_pkg::*;

module lcd_result_writer #(
  parameter int PWR_WAIT_CYC = 1000000,
  parameter int E_PULSE_CYC  = 25,
  parameter int CMD_WAIT_CYC = 2500,
  parameter int CLR_WAIT_CYC = 100000
`ifdef LCD_AUTO_REFRESH_EN
  , parameter int REFRESH_CYC = 5000000
`endif
) (
  input  logic                 clk,
  input  logic                 rst,
  lcd_result_writer_if.master  bus
);
  // Byte timing: cycle 0 setup, 1..E_PULSE_CYC enable high, then the wait.
  localparam logic [31:0] PWR_LAST = 32'(PWR_WAIT_CYC - 1);
  localparam logic [31:0] E_LAST   = 32'(E_PULSE_CYC);
  localparam logic [31:0] CMD_LAST = 32'(E_PULSE_CYC + CMD_WAIT_CYC);
  localparam logic [31:0] CLR_LAST = 32'(E_PULSE_CYC + CLR_WAIT_CYC);
  localparam logic [4:0]  IDX_LAST = 5'(LINE_LEN);

  state_t      state_reg;
  logic [31:0] cnt_reg;
  logic [4:0]  idx_reg;
  logic        pending_reg;
  logic        lcd_e_reg, lcd_rs_reg, busy_reg, done_reg;
  logic [7:0]  lcd_data_reg;
  logic        snap_train_reg, snap_o_reg;
  logic [6:0]  snap_prob_reg;
  logic [7:0]  snap_epoch_reg;

  logic        req, auto_req, byte_last;
  logic [3:0]  pos;
  logic [7:0]  line1_char, line2_char;
  logic [7:0]  prob_h, prob_t, prob_o, ep_h, ep_t, ep_o;

`ifdef LCD_AUTO_REFRESH_EN
  localparam logic [31:0] REFRESH_LAST = 32'(REFRESH_CYC - 1);
  logic [31:0] refresh_cnt_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      refresh_cnt_reg <= '0;
    else if (!bus.training_active || refresh_cnt_reg == REFRESH_LAST)
      refresh_cnt_reg <= '0;
    else
      refresh_cnt_reg <= refresh_cnt_reg + 32'd1;
  end

  assign auto_req = bus.training_active && (refresh_cnt_reg == REFRESH_LAST);
`else
  assign auto_req = 1'b0;
`endif

  assign req       = bus.start | auto_req;
  assign byte_last = (cnt_reg == ((state_reg == ST_INIT && idx_reg == 5'd3) ? CLR_LAST : CMD_LAST));
  // While the byte at idx_reg is on the bus, the next character is at position idx_reg.
  assign pos       = idx_reg[3:0];

  bin8_to_ascii3 u_prob_digits (
    .bin     ({1'b0, snap_prob_reg}),
    .ch_hund (prob_h),
    .ch_tens (prob_t),
    .ch_ones (prob_o)
  );

  bin8_to_ascii3 u_epoch_digits (
    .bin     (snap_epoch_reg),
    .ch_hund (ep_h),
    .ch_tens (ep_t),
    .ch_ones (ep_o)
  );

  always_comb begin
    line1_char = CH_SPACE;
    line2_char = CH_SPACE;
    if (snap_train_reg) begin
      case (pos)
        4'd0: line1_char = "T";
        4'd1: line1_char = "R";
        4'd2: line1_char = "A";
        4'd3: line1_char = "I";
        4'd4: line1_char = "N";
        4'd5: line1_char = "I";
        4'd6: line1_char = "N";
        4'd7: line1_char = "G";
        default: line1_char = CH_SPACE;
      endcase
      case (pos)
        4'd0: line2_char = "E";
        4'd1: line2_char = "P";
        4'd2: line2_char = "O";
        4'd3: line2_char = "C";
        4'd4: line2_char = "H";
        4'd6: line2_char = ep_h;
        4'd7: line2_char = ep_t;
        4'd8: line2_char = ep_o;
        default: line2_char = CH_SPACE;
      endcase
    end else begin
      case (pos)
        4'd0: line1_char = "R";
        4'd1: line1_char = "E";
        4'd2: line1_char = "S";
        4'd3: line1_char = "U";
        4'd4: line1_char = "L";
        4'd5: line1_char = "T";
        4'd6: line1_char = ":";
        4'd8: line1_char = snap_o_reg ? CH_O : CH_X;
        default: line1_char = CH_SPACE;
      endcase
      case (pos)
        4'd0: line2_char = "P";
        4'd1: line2_char = "(";
        4'd2: line2_char = "O";
        4'd3: line2_char = ")";
        4'd4: line2_char = "=";
        4'd5: line2_char = prob_h;
        4'd6: line2_char = prob_t;
        4'd7: line2_char = prob_o;
        4'd8: line2_char = CH_PCT;
        default: line2_char = CH_SPACE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg      <= ST_PWR_WAIT;
      cnt_reg        <= '0;
      idx_reg        <= '0;
      pending_reg    <= 1'b0;
      lcd_e_reg      <= 1'b0;
      lcd_rs_reg     <= 1'b0;
      lcd_data_reg   <= 8'h00;
      busy_reg       <= 1'b1;
      done_reg       <= 1'b0;
      snap_train_reg <= 1'b0;
      snap_o_reg     <= 1'b0;
      snap_prob_reg  <= '0;
      snap_epoch_reg <= '0;
    end else begin
      done_reg <= 1'b0;
      if (req && state_reg != ST_IDLE)
        pending_reg <= 1'b1;

      case (state_reg)
        ST_PWR_WAIT: begin
          if (cnt_reg == PWR_LAST) begin
            state_reg    <= ST_INIT;
            cnt_reg      <= '0;
            idx_reg      <= '0;
            lcd_rs_reg   <= 1'b0;
            lcd_data_reg <= init_cmd(2'd0);
          end else begin
            cnt_reg <= cnt_reg + 32'd1;
          end
        end

        ST_INIT, ST_LINE1, ST_LINE2: begin
          if (!byte_last) begin
            cnt_reg   <= cnt_reg + 32'd1;
            lcd_e_reg <= (cnt_reg < E_LAST);
          end else begin
            cnt_reg   <= '0;
            lcd_e_reg <= 1'b0;
            idx_reg   <= idx_reg + 5'd1;
            case (state_reg)
              ST_INIT: begin
                if (idx_reg == 5'd3) begin
                  state_reg <= ST_IDLE;
                  busy_reg  <= 1'b0;
                end else begin
                  lcd_rs_reg   <= 1'b0;
                  lcd_data_reg <= init_cmd(idx_reg[1:0] + 2'd1);
                end
              end
              ST_LINE1: begin
                if (idx_reg == IDX_LAST) begin
                  state_reg    <= ST_LINE2;
                  idx_reg      <= '0;
                  lcd_rs_reg   <= 1'b0;
                  lcd_data_reg <= CMD_LINE2;
                end else begin
                  lcd_rs_reg   <= 1'b1;
                  lcd_data_reg <= line1_char;
                end
              end
              default: begin
                if (idx_reg == IDX_LAST) begin
                  state_reg <= ST_FINISH;
                  done_reg  <= 1'b1;
                end else begin
                  lcd_rs_reg   <= 1'b1;
                  lcd_data_reg <= line2_char;
                end
              end
            endcase
          end
        end

        ST_IDLE: begin
          if (req || pending_reg) begin
            state_reg   <= ST_SNAP;
            busy_reg    <= 1'b1;
            pending_reg <= 1'b0;
          end
        end

        ST_SNAP: begin
          snap_train_reg <= bus.training_active;
          snap_o_reg     <= bus.result_is_O;
          snap_prob_reg  <= (bus.prob_pct > 7'd100) ? 7'd100 : bus.prob_pct;
          snap_epoch_reg <= bus.epoch;
          state_reg      <= ST_LINE1;
          cnt_reg        <= '0;
          idx_reg        <= '0;
          lcd_rs_reg     <= 1'b0;
          lcd_data_reg   <= CMD_LINE1;
        end

        default: begin
          state_reg <= ST_IDLE;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy     = busy_reg;
  assign bus.done     = done_reg;
  assign bus.lcd_e    = lcd_e_reg;
  assign bus.lcd_rw   = 1'b0;
  assign bus.lcd_rs   = lcd_rs_reg;
  assign bus.lcd_data = lcd_data_reg;

endmodule

// File: tb/tb_lcd_result_writer.sv
// Directed bench for lcd_result_writer with shortened LCD timing.
module tb_lcd_result_writer;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  lcd_result_writer_if bus_if ();

  lcd_result_writer #(
    .PWR_WAIT_CYC (20),
    .E_PULSE_CYC  (2),
    .CMD_WAIT_CYC (4),
    .CLR_WAIT_CYC (8)
`ifdef LCD_AUTO_REFRESH_EN
    , .REFRESH_CYC (600)
`endif
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  // Bus monitor: samples the cycle just ended at each rising edge.
  logic [8:0] cap_q[$];
  logic       prev_e = 1'b0;
  logic [8:0] held = '0;
  int         done_cnt = 0;
  int         stable_err = 0;
  int         rw_err = 0;

  always @(posedge clk) begin
    if (prev_e && !bus_if.lcd_e)
      cap_q.push_back({bus_if.lcd_rs, bus_if.lcd_data});
    if (bus_if.lcd_e) begin
      if (prev_e && ({bus_if.lcd_rs, bus_if.lcd_data} != held))
        stable_err++;
      held = {bus_if.lcd_rs, bus_if.lcd_data};
    end
    if (bus_if.lcd_rw)
      rw_err++;
    if (bus_if.done)
      done_cnt++;
    prev_e = bus_if.lcd_e;
  end

  function automatic string pad16(input string s);
    string r;
    r = s;
    while (r.len() < 16)
      r = {r, " "};
    return r;
  endfunction

  task automatic check_lines(input string tag, input string l1, input string l2);
    logic [8:0] exp;
    check_eq({tag, "_nbytes"}, 32'(cap_q.size()), 32'd34);
    if (cap_q.size() >= 34) begin
      for (int i = 0; i < 34; i++) begin
        if (i == 0)       exp = 9'h080;
        else if (i < 17)  exp = {1'b1, 8'(l1[i-1])};
        else if (i == 17) exp = 9'h0C0;
        else              exp = {1'b1, 8'(l2[i-18])};
        check_eq($sformatf("%s_b%0d", tag, i), 32'(cap_q[i]), 32'(exp));
      end
    end
  endtask

  task automatic check_init(input string tag);
    logic [8:0] exp_init [4];
    exp_init[0] = 9'h038; exp_init[1] = 9'h00C; exp_init[2] = 9'h006; exp_init[3] = 9'h001;
    check_eq({tag, "_nbytes"}, 32'(cap_q.size()), 32'd4);
    if (cap_q.size() >= 4)
      for (int i = 0; i < 4; i++)
        check_eq($sformatf("%s_b%0d", tag, i), 32'(cap_q[i]), 32'(exp_init[i]));
  endtask

  // Waits (bounded) at falling edges until done is seen.
  task automatic wait_done(input string tag, output int lat);
    lat = 0;
    while (!bus_if.done && lat < 1000) begin
      @(negedge clk);
      lat++;
    end
    if (!bus_if.done)
      check_eq({tag, "_timeout"}, 32'(bus_if.done), 32'd1);
  endtask

  // Called at a falling edge with the block idle.
  task automatic run_refresh(input string tag, output int lat);
    int l;
    cap_q.delete();
    bus_if.start = 1'b1;
    @(negedge clk);
    bus_if.start = 1'b0;
    wait_done(tag, l);
    lat = l + 1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    int lat;
    int n;
    bus_if.start = 1'b0;
    bus_if.training_active = 1'b0;
    bus_if.result_is_O = 1'b0;
    bus_if.prob_pct = '0;
    bus_if.epoch = '0;

    // 1: reset values, power wait and init sequence
    repeat (2) @(negedge clk);
    check_eq("rst_busy", 32'(bus_if.busy), 32'd1);
    check_eq("rst_e", 32'(bus_if.lcd_e), 32'd0);
    check_eq("rst_data", 32'(bus_if.lcd_data), 32'h00);
    check_eq("rst_done", 32'(bus_if.done), 32'd0);
    rst = 1'b1;
    cap_q.delete();
    k = 0;
    while (!bus_if.lcd_e && k < 100) begin
      @(negedge clk);
      k++;
      if (k == 20) check_eq("pwr_busy", 32'(bus_if.busy), 32'd1);
    end
    check_eq("first_e_rise_cycle", 32'(k), 32'd21);
    while (bus_if.busy && k < 200) begin
      @(negedge clk);
      k++;
    end
    check_eq("init_busy_fall_cycle", 32'(k), 32'd52);
    check_init("init");

    // 2: inference, O at 87 %
    bus_if.result_is_O = 1'b1;
    bus_if.prob_pct = 7'd87;
    n = done_cnt;
    run_refresh("inf87", lat);
    check_eq("inf87_latency", 32'(lat), 32'd240);
    @(negedge clk);
    check_eq("inf87_done_width", 32'(bus_if.done), 32'd0);
    check_eq("inf87_idle_busy", 32'(bus_if.busy), 32'd0);
    check_eq("inf87_done_count", 32'(done_cnt - n), 32'd1);
    check_lines("inf87", pad16("RESULT: O"), pad16("P(O)= 87%"));

    // 3: X with clamped and single-digit probability
    bus_if.result_is_O = 1'b0;
    bus_if.prob_pct = 7'd120;
    run_refresh("inf120", lat);
    check_eq("inf120_latency", 32'(lat), 32'd240);
    check_lines("inf120", pad16("RESULT: X"), pad16("P(O)=100%"));
    @(negedge clk);
    bus_if.prob_pct = 7'd5;
    run_refresh("inf5", lat);
    check_lines("inf5", pad16("RESULT: X"), pad16("P(O)=  5%"));
    @(negedge clk);

    // 4: training text, coalesced requests during a refresh
    bus_if.training_active = 1'b1;
    bus_if.epoch = 8'd7;
    n = done_cnt;
    cap_q.delete();
    bus_if.start = 1'b1;
    @(negedge clk);
    bus_if.start = 1'b0;
    repeat (40) @(negedge clk);
    bus_if.epoch = 8'd8;
    for (int p = 0; p < 3; p++) begin
      bus_if.start = 1'b1;
      @(negedge clk);
      bus_if.start = 1'b0;
      repeat (30) @(negedge clk);
    end
    wait_done("train1", lat);
    check_lines("train1", pad16("TRAINING"), pad16("EPOCH   7"));
    cap_q.delete();
    @(negedge clk);
    wait_done("train2", lat);
    bus_if.training_active = 1'b0;
    check_lines("train2", pad16("TRAINING"), pad16("EPOCH   8"));
    @(negedge clk);
    check_eq("train_idle_busy", 32'(bus_if.busy), 32'd0);
    repeat (300) @(negedge clk);
    check_eq("train_refresh_count", 32'(done_cnt - n), 32'd2);

    // 5: reset in the middle of line 1
    cap_q.delete();
    bus_if.start = 1'b1;
    @(negedge clk);
    bus_if.start = 1'b0;
    k = 0;
    while (!(cap_q.size() >= 3 && bus_if.lcd_e) && k < 200) begin
      @(negedge clk);
      k++;
    end
    check_eq("midline_reached", 32'(bus_if.lcd_e), 32'd1);
    #2 rst = 1'b0;
    #1;
    check_eq("abort_e", 32'(bus_if.lcd_e), 32'd0);
    check_eq("abort_data", 32'(bus_if.lcd_data), 32'h00);
    check_eq("abort_busy", 32'(bus_if.busy), 32'd1);
    check_eq("abort_done", 32'(bus_if.done), 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    cap_q.delete();
    k = 0;
    while (bus_if.busy && k < 200) begin
      @(negedge clk);
      k++;
    end
    check_eq("reinit_busy_fall_cycle", 32'(k), 32'd52);
    check_init("reinit");

`ifdef LCD_AUTO_REFRESH_EN
    // 6: periodic refresh while training, none once training stops
    begin
      int t_prev;
      int n_auto;
      t_prev = -1;
      n_auto = 0;
      bus_if.training_active = 1'b1;
      for (int c = 0; c < 2600; c++) begin
        @(negedge clk);
        if (bus_if.done) begin
          if (t_prev >= 0)
            check_eq($sformatf("auto_period_ge600_%0d", n_auto), 32'((c - t_prev) >= 600), 32'd1);
          t_prev = c;
          n_auto++;
        end
      end
      check_eq("auto_refresh_seen", 32'(n_auto >= 2), 32'd1);
      bus_if.training_active = 1'b0;
      k = 0;
      while (bus_if.busy && k < 400) begin
        @(negedge clk);
        k++;
      end
      n = done_cnt;
      repeat (1500) @(negedge clk);
      check_eq("auto_stopped", 32'(done_cnt - n), 32'd0);
    end
`endif

    check_eq("rw_always_low", 32'(rw_err), 32'd0);
    check_eq("data_stable_while_e", 32'(stable_err), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
